// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO with a selectable read mode.
//   FWFT=0: registered read, data valid the cycle after the pop.
//   FWFT=1: first-word-fall-through, head word held in an output register.
// Provides an occupancy count, almost-full/almost-empty flags and sticky
// overflow/underflow flags with a synchronous clear.
// Ports:
//   clk, rst_n       clock (rising edge), async active-low reset
//   wdata, winc      write data / write request
//   rinc             read request (pop)
//   err_clr          clears overflow/underflow (a same-cycle set wins)
//   rdata            read data
//   wfull, rempty    full / no readable word
//   walmost_full     count >= AFULL_THRESH
//   ralmost_empty    count <= AEMPTY_THRESH
//   count            words written and not yet popped (0..MEMDEPTH)
//   overflow         sticky: write attempted while full
//   underflow        sticky: read attempted while empty
module sync_fifo_flex #(
  parameter int unsigned DSIZE         = 32,
  parameter int unsigned ASIZE         = 9,
  parameter              RAM_TYPE      = "block",
  parameter int unsigned FWFT          = 0,
  parameter int unsigned AFULL_THRESH  = (1 << ASIZE) - 2,
  parameter int unsigned AEMPTY_THRESH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  input  logic             err_clr,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned    MEMDEPTH   = 1 << ASIZE;
  localparam logic [ASIZE:0] FULL_COUNT = {1'b1, {ASIZE{1'b0}}};

  (* ram_style = RAM_TYPE *) logic [DSIZE-1:0] mem [MEMDEPTH];

  logic [ASIZE:0] wptr;
  logic [ASIZE:0] rptr;
  logic           wr_ok;
  logic           rd_ok;
  logic           mem_nonempty;

  assign wfull         = (count == FULL_COUNT);
  assign walmost_full  = (32'(count) >= AFULL_THRESH);
  assign ralmost_empty = (32'(count) <= AEMPTY_THRESH);
  assign mem_nonempty  = (wptr != rptr);
  assign wr_ok         = winc && !wfull;
  assign rd_ok         = rinc && !rempty;

  // Storage is not reset so it can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr[ASIZE-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (winc && wfull)  overflow <= 1'b1;
      else if (err_clr)   overflow <= 1'b0;
      if (rinc && rempty) underflow <= 1'b1;
      else if (err_clr)   underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      logic ov;
      logic load;

      // The output register refills from memory whenever it is empty or
      // being popped, so count covers memory words plus the held head.
      assign load   = mem_nonempty && (!ov || rd_ok);
      assign rempty = !ov;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rptr  <= '0;
          ov    <= 1'b0;
          rdata <= '0;
        end else if (load) begin
          rdata <= mem[rptr[ASIZE-1:0]];
          rptr  <= rptr + 1'b1;
          ov    <= 1'b1;
        end else if (rd_ok) begin
          ov <= 1'b0;
        end
      end
    end else begin : g_reg
      // With no output register the pointer distance equals count.
      assign rempty = !mem_nonempty;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rptr  <= '0;
          rdata <= '0;
        end else if (rd_ok) begin
          rdata <= mem[rptr[ASIZE-1:0]];
          rptr  <= rptr + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
module tb_sync_fifo_flex;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wdata = '0;
  logic       winc = 1'b0, rinc = 1'b0, err_clr = 1'b0;

  logic [7:0] rdata0, rdata1;
  logic       wfull0, wfull1, rempty0, rempty1;
  logic       walmost_full0, walmost_full1, ralmost_empty0, ralmost_empty1;
  logic [2:0] count0, count1;
  logic       overflow0, overflow1, underflow0, underflow1;

  int errors = 0;
  int checks = 0;

  // Reference state: queue of stored words per instance.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] rd0;
  logic       vis1;
  logic       ovf0, unf0, ovf1, unf1;

  always #5 clk = ~clk;

  sync_fifo_flex #(.DSIZE(8), .ASIZE(2), .RAM_TYPE("distributed"), .FWFT(0),
                   .AFULL_THRESH(3), .AEMPTY_THRESH(1)) u_reg (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .rinc(rinc),
    .err_clr(err_clr), .rdata(rdata0), .wfull(wfull0), .rempty(rempty0),
    .walmost_full(walmost_full0), .ralmost_empty(ralmost_empty0),
    .count(count0), .overflow(overflow0), .underflow(underflow0));

  sync_fifo_flex #(.DSIZE(8), .ASIZE(2), .RAM_TYPE("distributed"), .FWFT(1),
                   .AFULL_THRESH(3), .AEMPTY_THRESH(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .rinc(rinc),
    .err_clr(err_clr), .rdata(rdata1), .wfull(wfull1), .rempty(rempty1),
    .walmost_full(walmost_full1), .ralmost_empty(ralmost_empty1),
    .count(count1), .overflow(overflow1), .underflow(underflow1));

  task automatic model_clear();
    q0.delete(); q1.delete();
    rd0 = '0; vis1 = 1'b0;
    ovf0 = 1'b0; unf0 = 1'b0; ovf1 = 1'b0; unf1 = 1'b0;
  endtask

  // Drive one cycle from a negedge, advance the models at the posedge,
  // return at the following negedge with inputs idle.
  task automatic step(input logic w, input logic r, input logic [7:0] d, input logic c);
    int   n0, n1;
    logic rdok1, load1;
    winc = w; rinc = r; wdata = d; err_clr = c;
    @(posedge clk);
    n0 = q0.size();
    ovf0 = (w && n0 == 4) ? 1'b1 : (c ? 1'b0 : ovf0);
    unf0 = (r && n0 == 0) ? 1'b1 : (c ? 1'b0 : unf0);
    if (r && n0 > 0) rd0 = q0.pop_front();
    if (w && n0 < 4) q0.push_back(d);
    n1 = q1.size();
    ovf1 = (w && n1 == 4) ? 1'b1 : (c ? 1'b0 : ovf1);
    unf1 = (r && !vis1) ? 1'b1 : (c ? 1'b0 : unf1);
    rdok1 = r && vis1;
    // A word becomes visible one edge after it is in storage behind the head.
    load1 = ((n1 - (vis1 ? 1 : 0)) > 0) && (!vis1 || rdok1);
    if (rdok1) void'(q1.pop_front());
    if (w && n1 < 4) q1.push_back(d);
    vis1 = load1 ? 1'b1 : (rdok1 ? 1'b0 : vis1);
    @(negedge clk);
    winc = 1'b0; rinc = 1'b0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({rdata0, rempty0, wfull0, count0, walmost_full0, ralmost_empty0, overflow0, underflow0}
        !== {8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_reg: got rdata=%0h re=%0b wf=%0b cnt=%0d af=%0b ae=%0b ov=%0b un=%0b expected 0 1 0 0 0 1 0 0",
               rdata0, rempty0, wfull0, count0, walmost_full0, ralmost_empty0, overflow0, underflow0);
    end
    checks++;
    if ({rdata1, rempty1, wfull1, count1, walmost_full1, ralmost_empty1, overflow1, underflow1}
        !== {8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_fwft: got rdata=%0h re=%0b wf=%0b cnt=%0d af=%0b ae=%0b ov=%0b un=%0b expected 0 1 0 0 0 1 0 0",
               rdata1, rempty1, wfull1, count1, walmost_full1, ralmost_empty1, overflow1, underflow1);
    end
  endtask

  task automatic test_fill();
    logic [7:0] v;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      v = 8'((i + 1) * 8'h11);
      step(1'b1, 1'b0, v, 1'b0);
      checks++;
      if ({count0, walmost_full0, wfull0} !== {3'(i + 1), (i >= 2), (i == 3)}) begin
        errors++;
        $display("FAIL fill_%0d: got cnt=%0d af=%0b wf=%0b expected cnt=%0d af=%0b wf=%0b",
                 i, count0, walmost_full0, wfull0, i + 1, (i >= 2), (i == 3));
      end
      checks++;
      if (count1 !== 3'(i + 1)) begin
        errors++;
        $display("FAIL fill_fwft_cnt_%0d: got %0d expected %0d", i, count1, i + 1);
      end
    end
    step(1'b1, 1'b0, 8'h55, 1'b0);
    checks++;
    if ({overflow0, overflow1, count0, count1} !== {1'b1, 1'b1, 3'd4, 3'd4}) begin
      errors++;
      $display("FAIL fill_overflow: got ov=%0b/%0b cnt=%0d/%0d expected 1/1 4/4",
               overflow0, overflow1, count0, count1);
    end
  endtask

  task automatic test_drain();
    logic [7:0] v;
    for (int i = 0; i < 4; i++) begin
      v = 8'((i + 1) * 8'h11);
      checks++;
      if ({rempty1, rdata1} !== {1'b0, v}) begin
        errors++;
        $display("FAIL drain_fwft_%0d: got re=%0b rdata=%0h expected 0 %0h", i, rempty1, rdata1, v);
      end
      step(1'b0, 1'b1, 8'h00, 1'b0);
      checks++;
      if (rdata0 !== v) begin
        errors++;
        $display("FAIL drain_reg_%0d: got %0h expected %0h", i, rdata0, v);
      end
    end
    checks++;
    if ({rempty0, rempty1} !== 2'b11) begin
      errors++;
      $display("FAIL drain_empty: got %0b%0b expected 11", rempty0, rempty1);
    end
    step(1'b0, 1'b1, 8'h00, 1'b0);
    checks++;
    if ({underflow0, underflow1, rdata0} !== {1'b1, 1'b1, 8'h44}) begin
      errors++;
      $display("FAIL drain_underflow: got un=%0b/%0b rdata=%0h expected 1/1 44",
               underflow0, underflow1, rdata0);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if ({overflow0, underflow0, overflow1, underflow1} !== 4'b0000) begin
      errors++;
      $display("FAIL err_clr: got %0b%0b%0b%0b expected 0000",
               overflow0, underflow0, overflow1, underflow1);
    end
  endtask

  task automatic test_fwft_latency();
    do_reset();
    step(1'b1, 1'b0, 8'hA5, 1'b0);
    checks++;
    if ({rempty1, count1} !== {1'b1, 3'd1}) begin
      errors++;
      $display("FAIL fwft_edge_n: got re=%0b cnt=%0d expected 1 1", rempty1, count1);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    checks++;
    if ({rempty1, rdata1} !== {1'b0, 8'hA5}) begin
      errors++;
      $display("FAIL fwft_edge_n1: got re=%0b rdata=%0h expected 0 a5", rempty1, rdata1);
    end
    step(1'b0, 1'b1, 8'h00, 1'b0);
    checks++;
    if ({rempty1, count1} !== {1'b1, 3'd0}) begin
      errors++;
      $display("FAIL fwft_pop: got re=%0b cnt=%0d expected 1 0", rempty1, count1);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h61 + i), 1'b0);
    step(1'b1, 1'b1, 8'h99, 1'b0);
    checks++;
    if ({rdata0, count0, overflow0} !== {8'h61, 3'd3, 1'b1}) begin
      errors++;
      $display("FAIL simul_full_reg: got rdata=%0h cnt=%0d ov=%0b expected 61 3 1", rdata0, count0, overflow0);
    end
    checks++;
    if ({rdata1, count1, overflow1} !== {8'h62, 3'd3, 1'b1}) begin
      errors++;
      $display("FAIL simul_full_fwft: got rdata=%0h cnt=%0d ov=%0b expected 62 3 1", rdata1, count1, overflow1);
    end
    do_reset();
    step(1'b1, 1'b1, 8'h77, 1'b0);
    checks++;
    if ({count0, underflow0, count1, underflow1} !== {3'd1, 1'b1, 3'd1, 1'b1}) begin
      errors++;
      $display("FAIL simul_empty: got cnt=%0d/%0d un=%0b/%0b expected 1/1 1/1",
               count0, count1, underflow0, underflow1);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    checks++;
    if ({rempty1, rdata1} !== {1'b0, 8'h77}) begin
      errors++;
      $display("FAIL simul_empty_data: got re=%0b rdata=%0h expected 0 77", rempty1, rdata1);
    end
  endtask

  task automatic test_stream();
    logic [7:0] out0[$];
    logic [7:0] out1[$];
    do_reset();
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h01, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) begin
      out1.push_back(rdata1);
      step(1'b1, 1'b1, 8'(i + 2), 1'b0);
      out0.push_back(rdata0);
      checks++;
      if ({count0, count1} !== {3'd2, 3'd2}) begin
        errors++;
        $display("FAIL stream_count_%0d: got %0d/%0d expected 2/2", i, count0, count1);
      end
    end
    for (int i = 0; i < 2; i++) begin
      out1.push_back(rdata1);
      step(1'b0, 1'b1, 8'h00, 1'b0);
      out0.push_back(rdata0);
    end
    for (int k = 0; k < 22; k++) begin
      checks++;
      if ({out0[k], out1[k]} !== {8'(k), 8'(k)}) begin
        errors++;
        $display("FAIL stream_data_%0d: got %0h/%0h expected %0h", k, out0[k], out1[k], k);
      end
    end
    checks++;
    if ({overflow0, underflow0, overflow1, underflow1} !== 4'b0000) begin
      errors++;
      $display("FAIL stream_errors: got %0b%0b%0b%0b expected 0000",
               overflow0, underflow0, overflow1, underflow1);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'hC3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rempty0, count0, rdata0, wfull0, overflow0, underflow0} !== {1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset_reg: got re=%0b cnt=%0d rdata=%0h wf=%0b ov=%0b un=%0b expected 1 0 0 0 0 0",
               rempty0, count0, rdata0, wfull0, overflow0, underflow0);
    end
    checks++;
    if ({rempty1, count1, rdata1, wfull1, overflow1, underflow1} !== {1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset_fwft: got re=%0b cnt=%0d rdata=%0h wf=%0b ov=%0b un=%0b expected 1 0 0 0 0 0",
               rempty1, count1, rdata1, wfull1, overflow1, underflow1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    step(1'b1, 1'b0, 8'h5A, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    checks++;
    if ({rempty1, rdata1} !== {1'b0, 8'h5A}) begin
      errors++;
      $display("FAIL async_after_fwft: got re=%0b rdata=%0h expected 0 5a", rempty1, rdata1);
    end
    step(1'b0, 1'b1, 8'h00, 1'b0);
    checks++;
    if ({rdata0, count0} !== {8'h5A, 3'd0}) begin
      errors++;
      $display("FAIL async_after_reg: got rdata=%0h cnt=%0d expected 5a 0", rdata0, count0);
    end
  endtask

  task automatic test_random();
    logic w, r, c;
    logic [7:0] exp_rd1;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 70 : 30));
      r = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 30 : 70));
      c = ($urandom_range(0, 15) == 0);
      step(w, r, 8'($urandom), c);
      checks++;
      if ({count0, rempty0, wfull0, walmost_full0, ralmost_empty0, overflow0, underflow0, rdata0} !==
          {3'(q0.size()), (q0.size() == 0), (q0.size() == 4), (q0.size() >= 3), (q0.size() <= 1),
           ovf0, unf0, rd0}) begin
        errors++;
        $display("FAIL random_reg_%0d: got cnt=%0d re=%0b wf=%0b af=%0b ae=%0b ov=%0b un=%0b rdata=%0h expected cnt=%0d ov=%0b un=%0b rdata=%0h",
                 i, count0, rempty0, wfull0, walmost_full0, ralmost_empty0, overflow0, underflow0, rdata0,
                 q0.size(), ovf0, unf0, rd0);
      end
      exp_rd1 = vis1 ? q1[0] : rdata1;
      checks++;
      if ({count1, rempty1, wfull1, walmost_full1, ralmost_empty1, overflow1, underflow1, rdata1} !==
          {3'(q1.size()), !vis1, (q1.size() == 4), (q1.size() >= 3), (q1.size() <= 1),
           ovf1, unf1, exp_rd1}) begin
        errors++;
        $display("FAIL random_fwft_%0d: got cnt=%0d re=%0b wf=%0b af=%0b ae=%0b ov=%0b un=%0b rdata=%0h expected cnt=%0d re=%0b ov=%0b un=%0b rdata=%0h",
                 i, count1, rempty1, wfull1, walmost_full1, ralmost_empty1, overflow1, underflow1, rdata1,
                 q1.size(), !vis1, ovf1, unf1, exp_rd1);
      end
    end
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    test_reset();
    test_fill();
    test_drain();
    test_fwft_latency();
    test_simultaneous();
    test_stream();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
